// File: rtl/tiny_cpu_core_p.sv
// ============================================================================
// Module   : tiny_cpu_core_p
// Brief    : Harvard multi-cycle CPU with a loadable 16-bit imem, DATA_W dmem,
//            a ready/valid output port and HALT. Optional MUL: TINY_CPU_MUL_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tiny_cpu_core_p #(
    parameter int DATA_W  = 8,
    parameter int REG_CNT = 4,
    parameter int IMEM_AW = 5,
    parameter int DMEM_AW = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               prog_we,
    input  logic [IMEM_AW-1:0] prog_addr,
    input  logic [15:0]        prog_data,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               halted,
    output logic [IMEM_AW-1:0] pc
);

    localparam int RIW    = $clog2(REG_CNT);
    localparam int IDEPTH = 1 << IMEM_AW;
    localparam int DDEPTH = 1 << DMEM_AW;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_EXEC     = 3'd2,
        S_OUT_WAIT = 3'd3,
        S_HALTED   = 3'd4
    } state_t;

    state_t             state_q;
    logic [IMEM_AW-1:0] pc_q;
    logic [15:0]        ir_q;
    logic [DATA_W-1:0]  regs_q [REG_CNT];
    logic [DATA_W-1:0]  out_data_q;
    logic               out_valid_q;
    logic               busy_q;
    logic               halted_q;

    logic [15:0]        imem_q [IDEPTH];
    logic [DATA_W-1:0]  dmem_q [DDEPTH];

    logic [3:0]         w_op;
    logic [RIW-1:0]     w_ra_idx;
    logic [RIW-1:0]     w_rb_idx;
    logic [DATA_W-1:0]  w_ra;
    logic [DATA_W-1:0]  w_rb;
    logic [DATA_W-1:0]  w_imm;
    logic [IMEM_AW-1:0] w_jmp;
    logic [IMEM_AW-1:0] w_pc_inc;
    logic [DMEM_AW-1:0] w_daddr;
    logic               w_prog_ok;
    logic [DATA_W-1:0]  res_d;
    logic               we_d;
    logic               taken_d;

    // Size casts both truncate (index bits above log2(REG_CNT), jump/dmem
    // addresses) and zero-extend (immediate for wide data paths).
    assign w_op      = ir_q[15:12];
    assign w_ra_idx  = RIW'(ir_q[11:8]);
    assign w_rb_idx  = RIW'(ir_q[7:4]);
    assign w_ra      = regs_q[w_ra_idx];
    assign w_rb      = regs_q[w_rb_idx];
    assign w_imm     = DATA_W'(ir_q[7:0]);
    assign w_jmp     = IMEM_AW'(ir_q[7:0]);
    assign w_daddr   = DMEM_AW'(ir_q[7:0]);
    assign w_pc_inc  = pc_q + IMEM_AW'(1);
    assign w_prog_ok = (state_q == S_IDLE) || (state_q == S_HALTED);

    always_comb begin
        res_d   = w_ra;
        we_d    = 1'b0;
        taken_d = 1'b0;
        case (w_op)
            4'h1: begin res_d = w_imm;            we_d = 1'b1; end
            4'h2: begin res_d = dmem_q[w_daddr];  we_d = 1'b1; end
            4'h4: begin res_d = w_ra + w_rb;      we_d = 1'b1; end
            4'h5: begin res_d = w_ra - w_rb;      we_d = 1'b1; end
            4'h6: begin res_d = w_ra & w_rb;      we_d = 1'b1; end
            4'h7: begin res_d = w_ra ^ w_rb;      we_d = 1'b1; end
            4'h8: begin res_d = w_ra | w_rb;      we_d = 1'b1; end
            4'h9: begin res_d = w_ra << 1;        we_d = 1'b1; end
            4'hA: taken_d = (w_ra == '0);
            4'hB: taken_d = (w_ra != '0);
            4'hC: taken_d = 1'b1;
`ifdef TINY_CPU_MUL_EN
            4'hF: begin res_d = w_ra * w_rb;      we_d = 1'b1; end
`endif
            default: ;
        endcase
    end

    // Memories carry no reset so they map onto plain RAM.
    always_ff @(posedge clk) begin
        if (prog_we && w_prog_ok)
            imem_q[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk) begin
        if (state_q == S_EXEC && w_op == 4'h3)
            dmem_q[w_daddr] <= w_ra;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            for (int i = 0; i < REG_CNT; i++)
                regs_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        state_q  <= S_FETCH;
                        pc_q     <= '0;
                        busy_q   <= 1'b1;
                        halted_q <= 1'b0;
                    end
                end
                S_FETCH: begin
                    ir_q    <= imem_q[pc_q];
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (we_d)
                        regs_q[w_ra_idx] <= res_d;
                    if (w_op == 4'hD) begin
                        out_data_q  <= w_ra;
                        out_valid_q <= 1'b1;
                        state_q     <= S_OUT_WAIT;
                    end else if (w_op == 4'hE) begin
                        state_q  <= S_HALTED;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        pc_q    <= taken_d ? w_jmp : w_pc_inc;
                        state_q <= S_FETCH;
                    end
                end
                S_OUT_WAIT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        pc_q        <= w_pc_inc;
                        state_q     <= S_FETCH;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    busy_q   <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign halted    = halted_q;
    assign pc        = pc_q;

endmodule

`default_nettype wire

// File: doc/tiny_cpu_core_p.md
Name: tiny_cpu_core_p

Overview:
Parametrised successor to the team's 8-bit demo CPU. It is a Harvard-style multi-cycle core with:
- a generic register file;
- a loadable 16-bit instruction memory;
- a DATA_W-wide data memory;
- a ready/valid output port and a HALT instruction.
It sits behind the tt_um top wrapper. The wrapper drives program loading and observes the output stream.

Parameters:
DATA_W, 8, data path / register / data-memory word width (4..32)
REG_CNT, 4, number of registers (power of 2, 2..16); index = low log2(REG_CNT) bits of field
IMEM_AW, 5, instruction memory address width (depth 2^IMEM_AW, 1..8)
DMEM_AW, 4, data memory address width (depth 2^DMEM_AW, 1..8)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  1-cycle pulse; begins execution at PC=0 when IDLE or HALTED
prog_we  in  1  instruction write strobe; honoured only in IDLE or HALTED
prog_addr  in  IMEM_AW  instruction write address
prog_data  in  16  instruction word
out_data  out  DATA_W  value emitted by OUT
out_valid  out  1  out_data valid; held until accepted
out_ready  in  1  sink accepts when out_valid&&out_ready at clock edge
busy  out  1  high in FETCH, EXEC, OUT_WAIT
halted  out  1  high in HALTED
pc  out  IMEM_AW  current program counter

Behaviour:
- Instruction fields: op=[15:12], rA=[11:8], rB=[7:4], imm=[7:0].
- Opcodes:
  - 0 NOP
  - 1 LDI rA=imm (zero-extended, or low DATA_W bits if DATA_W<8)
  - 2 LD rA=dmem[imm mod depth]
  - 3 ST dmem[imm mod depth]=rA
  - 4 ADD, 5 SUB, 6 AND, 7 XOR, 8 OR: rA = rA op rB
  - 9 SHL: rA = rA<<1
  - A JZ: if rA==0 then PC=imm
  - B JNZ: if rA!=0 then PC=imm
  - C JMP: PC=imm
  - D OUT rA
  - E HALT
  - F see optional feature
- Arithmetic is modulo 2^DATA_W; carries and borrows are discarded. Jump targets are truncated to IMEM_AW bits. PC+1 wraps from 2^IMEM_AW-1 to 0.
- Reset (async) sets: state=IDLE, PC=0, all registers=0, out_valid=0, out_data=0, busy=0, halted=0. Memories are not reset.
- FSM:
  - IDLE: prog_we writes imem. start → FETCH with PC=0.
  - FETCH: latch imem[PC] into instruction register → EXEC.
  - EXEC: perform op, update PC (jump target or PC+1), → FETCH. OUT → OUT_WAIT. HALT → HALTED.
  - OUT_WAIT: out_valid=1 with out_data stable. On out_valid&&out_ready: out_valid=0, PC=PC+1 → FETCH.
  - HALTED: PC frozen at HALT address. prog_we allowed. start → FETCH with PC=0; registers and dmem are retained.
- Latency: 2 cycles per instruction, plus 1+stall cycles for OUT.
- In EXEC, OUT loads out_data and raises out_valid on the same edge, so out_valid is seen in the first OUT_WAIT cycle. A zero-stall OUT therefore takes 3 cycles.
- start while busy: ignored. prog_we while busy: ignored, imem unchanged.
- Simultaneous start and prog_we in IDLE: the write occurs, and FETCH reads the new word if the address is 0.
- Reset mid-operation: immediate return to reset state. A pending out_valid is dropped.
- LD followed by ST to the same address: ordered by instruction sequence, no hazard.
- Register-index bits above log2(REG_CNT) are ignored.

Optional Feature:
TINY_CPU_MUL_EN:
- Defined: opcode F = MUL, rA = low DATA_W bits of rA*rB, timing identical to ALU ops.
- Undefined: opcode F executes as NOP and no multiplier is synthesised.

Test Plan:
- Load {LDI r0,5; LDI r1,3; ADD r0,r1; OUT r0; HALT}, pulse start, out_ready=1 → out_data=8 with one out_valid pulse, then halted=1 with pc=4.
- Countdown: LDI r0,3; LDI r1,1; OUT r0; SUB r0,r1; JNZ r0,2; HALT → output stream 3,2,1, then halted.
- Hold out_ready=0 for 5 cycles during OUT → out_valid stays 1 with out_data stable for all 5; pc does not advance; accepted on the first ready cycle.
- DATA_W=8: LDI r0,0xFF; LDI r1,1; ADD; OUT → 0x00. SUB 0-1 → 0xFF. JMP 0x3F with IMEM_AW=5 → pc=31.
- ST r0,[0x13] then LD r2,[0x03] with DMEM_AW=4 → r2 equals r0 (address wrap). prog_we during busy → imem unchanged.
- Assert reset while in OUT_WAIT → out_valid=0, busy=0, pc=0 on the next edge. With TINY_CPU_MUL_EN, MUL 7*6 → out 42. Without it, opcode F leaves registers unchanged.
